// File: rtl/pwm4_gen.sv
// PWM generator slaved to an upstream free-running 4-bit counter.
// The duty value is double-buffered so it only changes on period boundaries while running.
module pwm4_gen (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] CNT,
    input  logic       COUT,
    input  logic       EN,
    input  logic [3:0] DUTY,
    input  logic       DUTY_VALID,
    output logic       DUTY_READY,
    output logic       PWM,
    output logic [3:0] O,
    output logic [7:0] PERIODS,
    output logic       DONE,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [3:0] active_q;
    logic [3:0] active_d;
    logic [3:0] shadow_q;
    logic [3:0] shadow_d;
    logic       pending_q;
    logic       pending_d;
    logic       pwm_q;
    logic       pwm_d;
    logic       done_q;
    logic       done_d;
    logic [7:0] periods_q;
    logic [7:0] periods_d;

    logic       in_period;
    logic       accept;

    // Duty handshake: a word moves when DUTY_VALID and DUTY_READY are both high at a
    // rising CLK edge; READY depends only on the pending flag, never on VALID, and a
    // source seeing VALID without READY must hold DUTY stable until it is accepted.
    assign DUTY_READY = ~pending_q;
    assign accept     = DUTY_VALID & ~pending_q;
    assign in_period  = (state_q == SYNC) || (state_q == RUN);

    // Next-state logic; dropping EN wins over every other transition.
    always_comb begin
        state_d = state_q;
        if (!EN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SYNC;
                SYNC:    if (COUT) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Duty buffering: while aligned to the counter, active only moves in the COUT cycle,
    // either from the shadow or straight from the bus when nothing is pending.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (in_period && COUT) begin
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end else if (accept) begin
                active_d = DUTY;
            end
        end else begin
            if (accept) begin
                shadow_d  = DUTY;
                pending_d = 1'b1;
            end else if ((state_q == IDLE) && pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    // Output stage: PWM is registered, so it lags the counter by one cycle.
    always_comb begin
        pwm_d     = (state_q == RUN) && EN && (CNT < active_q);
        done_d    = (state_q == RUN) && COUT;
        periods_d = periods_q;
        if (done_d && (periods_q != 8'hFF)) begin
            periods_d = periods_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            active_q  <= 4'd0;
            shadow_q  <= 4'd0;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
            periods_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
            periods_q <= periods_d;
        end
    end

    assign PWM       = pwm_q;
    assign O         = active_q;
    assign PERIODS   = periods_q;
    assign DONE      = done_q;
    assign state_dbg = state_q;

endmodule

// File: doc/pwm4_gen.md
PWM4_GEN -- requirements
Module: pwm4_gen

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port CNT  input  4  free-running count from the upstream 4-bit counter (0..15, +1 per CLK, wraps).
REQ-004 SHALL have port COUT  input  1  upstream carry-out; high during the cycle CNT==15 (last cycle of period).
REQ-005 SHALL have port EN  input  1  enable PWM generation.
REQ-006 SHALL have port DUTY  input  4  requested duty value, 0..15.
REQ-007 SHALL have port DUTY_VALID  input  1  DUTY is presented.
REQ-008 SHALL have port DUTY_READY  output  1  block can accept DUTY.
REQ-009 SHALL have port PWM  output  1  registered PWM waveform.
REQ-010 SHALL have port O  output  4  active duty value currently in use.
REQ-011 SHALL have port PERIODS  output  8  count of completed RUN periods, saturating.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse at each completed RUN period.

Function
REQ-013 SHALL hold state IDLE, SYNC, RUN; encoding free.
REQ-014 IDLE: EN=1 -> SYNC next edge; else stay.
REQ-015 SYNC: waits for period alignment; COUT=1 and EN=1 -> RUN next edge, so RUN starts at CNT==0.
REQ-016 RUN: EN=0 -> IDLE next edge; otherwise stay.
REQ-017 Any state with EN=0 SHALL go to IDLE next edge (overrides other transitions).
REQ-018 PWM SHALL be 0 in IDLE and SYNC; in RUN, PWM(t+1) = (CNT(t) < active) — fixed 1-cycle latency, unsigned 4-bit compare.
REQ-019 active=0 SHALL give PWM constantly low; active=15 SHALL give 15 high cycles per 16.
REQ-020 SHALL hold one shadow register plus pending flag; DUTY_READY = not pending (combinational from flag only, not from DUTY_VALID).
REQ-021 Transfer occurs on DUTY_VALID & DUTY_READY at a rising edge; DUTY_VALID without READY SHALL be ignored (source holds).
REQ-022 Transfer when COUT=0, or state not RUN/SYNC: DUTY -> shadow, pending set.
REQ-023 Transfer in a cycle with COUT=1 while pending clear: DUTY -> active directly (bypass), pending stays clear.
REQ-024 COUT=1 with pending set: shadow -> active, pending cleared; READY goes high next cycle.
REQ-025 In IDLE, pending shadow SHALL also be applied to active immediately (next edge); no COUT needed.
REQ-026 active SHALL change only at period boundary in SYNC/RUN; new value governs from the following CNT==0 onward.
REQ-027 O SHALL equal active at all times.
REQ-028 DONE SHALL pulse 1 for exactly the cycle after a COUT=1 cycle spent in RUN; never in IDLE/SYNC.
REQ-029 PERIODS SHALL increment with each DONE, saturating at 255 (no wrap); cleared only by RESET.
REQ-030 EN drop mid-period SHALL force PWM 0 next edge; partial period SHALL NOT count as DONE.

Reset
REQ-031 RESET=1 at an edge SHALL force: state IDLE, PWM 0, O 0, pending 0 (DUTY_READY 1), PERIODS 0, DONE 0.
REQ-032 RESET SHALL override EN, COUT and handshake in the same cycle; a transfer presented during RESET is discarded.
REQ-033 RESET mid-RUN SHALL take effect at the next edge regardless of CNT position.

Verification
REQ-034 Reset, DUTY=5 loaded in IDLE, EN=1 -> after first COUT enters RUN; per period PWM high exactly 5 cycles (CNT 0..4, seen one cycle late), DONE pulses, PERIODS 1,2,3.
REQ-035 RUN duty 5, load DUTY=12 at CNT=7 -> READY low until period end; next period 12 high cycles; second write during pending stalled (VALID held, no accept).
REQ-036 Write DUTY=9 exactly in COUT cycle with pending clear -> O=9 next edge, READY stays 1, next period 9 high cycles.
REQ-037 Duty 0 and duty 15 -> 0 and 15 high cycles per period respectively.
REQ-038 EN low at CNT=6 mid-RUN -> PWM 0 next edge, no DONE, PERIODS unchanged; EN high again -> SYNC, RUN resumes at CNT 0.
REQ-039 300 RUN periods -> PERIODS holds 255; RESET asserted mid-period -> all outputs at reset values next edge.
